// File: rtl/cbd_sampler_param.sv
// cbd_sampler_param
//   Centred-binomial noise sampler. For each of NBLK blocks it absorbs the
//   32-byte seed (8 words from the seed RAM), then {nonce, blk, 16'h0} into
//   SHAKE256. It captures one squeezed block of BLOCK_BITS bits and converts
//   it into CPB coefficients in [0, Q-1], written one per clock to the
//   polynomial RAM.
//
//   Build option: define CBD_SAMPLER_BITREV_EN to write coefficients at the
//   AW-bit bit-reversed address (NTT order). Data and timing do not change.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   start, nonce      start pulse (ignored while busy); nonce captured on start
//   busy, done        run in progress; one-cycle pulse after the final write
//   byte_addr/byte_do seed RAM word address / read data (read latency 1)
//   poly_wea/addra/dia
//                     polynomial RAM write port
//   shake_rst         SHAKE core reset
//   shake_in/_ready/_is_last/_byte_num
//                     absorb word stream
//   shake_out/_ready  squeezed block (MSB-first index) and its valid strobe
module cbd_sampler_param #(
  parameter int N          = 1024,
  parameter int K          = 8,
  parameter int Q          = 12289,
  parameter int BLOCK_BITS = 1024,
  parameter int COEF_W     = 16,
  localparam int CPB       = BLOCK_BITS / (2 * K),
  localparam int NBLK      = N / CPB,
  localparam int AW        = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              nonce,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              byte_addr,
  input  logic [31:0]             byte_do,
  output logic                    poly_wea,
  output logic [AW-1:0]           poly_addra,
  output logic [COEF_W-1:0]       poly_dia,
  output logic                    shake_rst,
  output logic [31:0]             shake_in,
  output logic                    shake_in_ready,
  output logic                    shake_is_last,
  output logic [1:0]              shake_byte_num,
  input  logic [0:BLOCK_BITS-1]   shake_out,
  input  logic                    shake_out_ready
);

  localparam int PW = $clog2(K + 1);
  localparam int BW = $clog2(BLOCK_BITS);
  localparam logic [COEF_W-1:0] QW = COEF_W'(Q);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LAST,
    WAIT_SHAKE,
    PARSE
  } state_t;

  state_t                state_q;
  logic [7:0]            nonce_q;
  logic [7:0]            blk_q;
  logic [3:0]            word_q;
  logic [AW-1:0]         c_q;
  logic                  issuing_q;
  logic [0:BLOCK_BITS-1] buf_q;

  logic                  busy_q;
  logic                  done_q;
  logic [2:0]            byte_addr_q;
  logic                  shake_rst_q;
  logic                  shake_in_ready_q;
  logic                  shake_is_last_q;
  logic [1:0]            shake_byte_num_q;

  // Stage 1: popcounts
  logic                  v1_q;
  logic                  last1_q;
  logic [PW-1:0]         a1_q;
  logic [PW-1:0]         b1_q;
  logic [AW-1:0]         addr1_q;
  // Stage 2: reduced difference
  logic                  v2_q;
  logic                  last2_q;
  logic [COEF_W-1:0]     r2_q;
  logic [AW-1:0]         addr2_q;
  // Stage 3: RAM write port
  logic                  poly_wea_q;
  logic                  last3_q;
  logic [AW-1:0]         poly_addra_q;
  logic [COEF_W-1:0]     poly_dia_q;

  logic [BW-1:0]         base_d;
  logic [PW-1:0]         a_d;
  logic [PW-1:0]         b_d;
  logic [AW-1:0]         addr1_d;
  logic [COEF_W-1:0]     ae_d;
  logic [COEF_W-1:0]     be_d;
  logic [COEF_W-1:0]     r2_d;
  logic [AW-1:0]         addr3_d;
  logic [31:0]           shake_in_d;

  function automatic logic [PW-1:0] popcount(input logic [K-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < K; i++) begin
      n = n + PW'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < AW; i++) begin
      r[i] = v[AW-1-i];
    end
    return r;
  endfunction

  always_comb begin
    base_d  = BW'(c_q) * BW'(2 * K);
    a_d     = popcount(buf_q[base_d +: K]);
    b_d     = popcount(buf_q[base_d + BW'(K) +: K]);
    addr1_d = AW'(int'(blk_q) * CPB + int'(c_q));

    // Both operands are at most K, so one conditional add of Q fully reduces.
    ae_d = COEF_W'(a1_q);
    be_d = COEF_W'(b1_q);
    r2_d = (a1_q >= b1_q) ? (ae_d - be_d) : (QW - be_d + ae_d);

`ifdef CBD_SAMPLER_BITREV_EN
    addr3_d = bitrev(addr2_q);
`else
    addr3_d = addr2_q;
`endif

    shake_in_d = '0;
    if (shake_is_last_q) begin
      shake_in_d = {nonce_q, blk_q, 16'h0000};
    end else if (shake_in_ready_q) begin
      // Seed RAM data arrives the cycle after its address and is passed
      // straight through so the 8 seed words are absorbed back-to-back.
      shake_in_d = byte_do;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == WAIT_SHAKE && shake_out_ready) begin
      buf_q <= shake_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      nonce_q          <= '0;
      blk_q            <= '0;
      word_q           <= '0;
      c_q              <= '0;
      issuing_q        <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      byte_addr_q      <= '0;
      shake_rst_q      <= 1'b1;
      shake_in_ready_q <= 1'b0;
      shake_is_last_q  <= 1'b0;
      shake_byte_num_q <= '0;
      v1_q             <= 1'b0;
      last1_q          <= 1'b0;
      a1_q             <= '0;
      b1_q             <= '0;
      addr1_q          <= '0;
      v2_q             <= 1'b0;
      last2_q          <= 1'b0;
      r2_q             <= '0;
      addr2_q          <= '0;
      poly_wea_q       <= 1'b0;
      last3_q          <= 1'b0;
      poly_addra_q     <= '0;
      poly_dia_q       <= '0;
    end else begin
      v1_q    <= issuing_q;
      last1_q <= issuing_q && (c_q == AW'(CPB - 1));
      a1_q    <= a_d;
      b1_q    <= b_d;
      addr1_q <= addr1_d;

      v2_q    <= v1_q;
      last2_q <= v1_q && last1_q;
      r2_q    <= r2_d;
      addr2_q <= addr1_q;

      poly_wea_q <= v2_q;
      last3_q    <= v2_q && last2_q;
      if (v2_q) begin
        poly_addra_q <= addr3_d;
        poly_dia_q   <= r2_q;
      end

      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          shake_rst_q <= 1'b1;
          if (start) begin
            nonce_q     <= nonce;
            blk_q       <= '0;
            busy_q      <= 1'b1;
            word_q      <= '0;
            byte_addr_q <= '0;
            shake_rst_q <= 1'b0;
            state_q     <= LOAD;
          end
        end

        LOAD: begin
          shake_rst_q <= 1'b0;
          if (word_q == 4'd8) begin
            shake_in_ready_q <= 1'b1;
            shake_is_last_q  <= 1'b1;
            shake_byte_num_q <= 2'd2;
            state_q          <= LAST;
          end else begin
            byte_addr_q      <= byte_addr_q + 3'd1;
            shake_in_ready_q <= 1'b1;
            word_q           <= word_q + 4'd1;
          end
        end

        LAST: begin
          shake_in_ready_q <= 1'b0;
          shake_is_last_q  <= 1'b0;
          shake_byte_num_q <= '0;
          state_q          <= WAIT_SHAKE;
        end

        WAIT_SHAKE: begin
          if (shake_out_ready) begin
            issuing_q <= 1'b1;
            c_q       <= '0;
            state_q   <= PARSE;
          end
        end

        PARSE: begin
          if (issuing_q) begin
            c_q <= c_q + AW'(1);
            if (c_q == AW'(CPB - 1)) begin
              issuing_q <= 1'b0;
            end
          end
          // The block ends when the final coefficient leaves the write stage.
          if (poly_wea_q && last3_q) begin
            shake_rst_q <= 1'b1;
            if (blk_q == 8'(NBLK - 1)) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              blk_q       <= blk_q + 8'd1;
              word_q      <= '0;
              byte_addr_q <= '0;
              state_q     <= LOAD;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign byte_addr      = byte_addr_q;
  assign poly_wea       = poly_wea_q;
  assign poly_addra     = poly_addra_q;
  assign poly_dia       = poly_dia_q;
  assign shake_rst      = shake_rst_q;
  assign shake_in       = shake_in_d;
  assign shake_in_ready = shake_in_ready_q;
  assign shake_is_last  = shake_is_last_q;
  assign shake_byte_num = shake_byte_num_q;

endmodule

// File: tb/tb_cbd_sampler_param.sv
// Scoreboard bench for cbd_sampler_param with a reactive SHAKE model and
// a seed RAM model.
module tb_cbd_sampler_param;
  localparam int N    = 1024;
  localparam int K    = 8;
  localparam int Q    = 12289;
  localparam int BB   = 1024;
  localparam int CW   = 16;
  localparam int CPB  = BB / (2 * K);
  localparam int NBLK = N / CPB;
  localparam int AW   = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    nonce;
  logic          busy, done;
  logic [2:0]    byte_addr;
  logic [31:0]   byte_do;
  logic          poly_wea;
  logic [AW-1:0] poly_addra;
  logic [CW-1:0] poly_dia;
  logic          shake_rst;
  logic [31:0]   shake_in;
  logic          shake_in_ready, shake_is_last;
  logic [1:0]    shake_byte_num;
  logic [0:BB-1] shake_out;
  logic          shake_out_ready;

  cbd_sampler_param #(.N(N), .K(K), .Q(Q), .BLOCK_BITS(BB), .COEF_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .nonce(nonce), .busy(busy), .done(done),
    .byte_addr(byte_addr), .byte_do(byte_do), .poly_wea(poly_wea),
    .poly_addra(poly_addra), .poly_dia(poly_dia), .shake_rst(shake_rst),
    .shake_in(shake_in), .shake_in_ready(shake_in_ready),
    .shake_is_last(shake_is_last), .shake_byte_num(shake_byte_num),
    .shake_out(shake_out), .shake_out_ready(shake_out_ready)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] seed [8];
  always @(posedge clk) byte_do <= seed[byte_addr];

  typedef struct { int unsigned addr; int unsigned data; int unsigned at; } wr_t;
  typedef struct { logic [31:0] w; logic last; } ab_t;
  wr_t wq[$];
  ab_t aq[$];

  int checks = 0;
  int errors = 0;
  int mode = 0;
  int blk_sent = 0;
  int wcount = 0;
  int done_cnt = 0;
  int rstp_cnt = 0;
  int ab_idx = 0;
  int unsigned last_ab_cyc = 0;
  int pend = 0;
  int junk = 0;
  bit seen [N];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int unsigned ref_addr(input int unsigned natural);
    int unsigned r;
    r = natural;
`ifdef CBD_SAMPLER_BITREV_EN
    r = 0;
    for (int i = 0; i < AW; i++)
      if (((natural >> i) & 1) != 0) r = r | (1 << (AW - 1 - i));
`endif
    return r;
  endfunction

  // Build one squeezed block from the current pattern and queue the writes it implies.
  task automatic deliver();
    logic [0:BB-1] bits;
    logic [K-1:0]  ab, bb;
    int na, nb;
    wr_t e;
    for (int c = 0; c < CPB; c++) begin
      case (mode)
        0:       begin ab = '0;         bb = '0;         end
        1:       begin ab = '1;         bb = '0;         end
        2:       begin ab = '0;         bb = '1;         end
        3:       begin ab = K'(8'h0F);  bb = K'(8'h01);  end
        default: begin ab = K'($urandom()); bb = K'($urandom()); end
      endcase
      for (int j = 0; j < K; j++) begin
        bits[2*K*c + j]     = ab[j];
        bits[2*K*c + K + j] = bb[j];
      end
    end
    for (int c = 0; c < CPB; c++) begin
      na = 0; nb = 0;
      for (int j = 0; j < K; j++) begin
        na += int'(bits[2*K*c + j]);
        nb += int'(bits[2*K*c + K + j]);
      end
      e.addr = ref_addr(blk_sent * CPB + c);
      e.data = (na - nb + Q) % Q;
      e.at   = cyc + 4 + c;
      wq.push_back(e);
    end
    shake_out = bits;
    shake_out_ready = 1'b1;
    blk_sent++;
    junk = 10;
  endtask

  // SHAKE model: answers each final absorb after a short random delay, and
  // later fires a stray valid with garbage data that the DUT must ignore.
  initial begin
    shake_out_ready = 1'b0;
    shake_out = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0; junk = 0;
      end else if (shake_in_ready && shake_is_last) begin
        pend = $urandom_range(2, 5);
      end
      #1;
      shake_out_ready = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) deliver();
      end else if (junk > 0) begin
        junk--;
        if (junk == 0) begin
          for (int i = 0; i < BB / 32; i++) shake_out[32*i +: 32] = $urandom();
          shake_out_ready = 1'b1;
        end
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    wr_t e;
    ab_t a;
    if (poly_wea) begin
      wcount++;
      seen[poly_addra] = 1'b1;
      if (wq.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = wq.pop_front();
        chk("wr_addr", poly_addra, e.addr);
        chk("wr_data", poly_dia, e.data);
        chk("wr_cycle", cyc, e.at);
      end
    end
    if (shake_in_ready) begin
      if (aq.size() == 0) chk("unexpected_absorb", 1, 0);
      else begin
        a = aq.pop_front();
        chk("absorb_word", shake_in, a.w);
        chk("absorb_last", shake_is_last, a.last);
        if (a.last) chk("byte_num", shake_byte_num, 2);
        if (ab_idx != 0) chk("absorb_gap", cyc, last_ab_cyc + 1);
        chk("shake_rst_absorb", shake_rst, 0);
        last_ab_cyc = cyc;
        ab_idx = a.last ? 0 : ab_idx + 1;
      end
    end else begin
      chk("shake_in_idle", shake_in, 0);
    end
    if (done) done_cnt++;
    if (busy && shake_rst) rstp_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int m, input bit incseed, input bit restart, input bit abort);
    logic [7:0] nn;
    ab_t a;
    int t, nseen;
    bit did;
    mode = m;
    nn = 8'($urandom());
    if (incseed) nn = 8'hA5;
    for (int i = 0; i < 8; i++) seed[i] = incseed ? 32'(i) : $urandom();
    wq.delete(); aq.delete();
    for (int b = 0; b < NBLK; b++) begin
      for (int i = 0; i < 8; i++) begin a.w = seed[i]; a.last = 1'b0; aq.push_back(a); end
      a.w = {nn, 8'(b), 16'h0000}; a.last = 1'b1; aq.push_back(a);
    end
    for (int i = 0; i < N; i++) seen[i] = 1'b0;
    wcount = 0; done_cnt = 0; rstp_cnt = 0; blk_sent = 0; ab_idx = 0;
    start = 1'b1; nonce = nn;
    tick();
    start = 1'b0; nonce = ~nn;
    chk("busy_after_start", busy, 1);
    t = 0; did = 1'b0;
    while (done_cnt == 0 && t < 20000) begin
      tick(); t++;
      start = 1'b0;
      if (restart && !did && blk_sent == 6) begin start = 1'b1; did = 1'b1; end
      if (abort && wcount == 3 * CPB + 20) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wq.delete(); aq.delete();
        chk("abort_wea", poly_wea, 0);
        chk("abort_shake_rst", shake_rst, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (100) tick();
        chk("abort_no_writes", wcount, 3 * CPB + 20);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle_busy", busy, 0);
        return;
      end
    end
    start = 1'b0;
    if (done_cnt == 0) begin
      chk("done_timeout", 0, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      return;
    end
    repeat (8) tick();
    nseen = 0;
    for (int i = 0; i < N; i++) nseen += int'(seen[i]);
    chk("write_count", wcount, N);
    chk("addr_coverage", nseen, N);
    chk("done_pulses", done_cnt, 1);
    chk("block_shake_rst", rstp_cnt, NBLK - 1);
    chk("wq_empty", wq.size(), 0);
    chk("aq_empty", aq.size(), 0);
    chk("busy_end", busy, 0);
    chk("shake_rst_idle", shake_rst, 1);
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; nonce = '0;
    for (int i = 0; i < 8; i++) seed[i] = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wea", poly_wea, 0);
    chk("rst_addra", poly_addra, 0);
    chk("rst_dia", poly_dia, 0);
    chk("rst_byte_addr", byte_addr, 0);
    chk("rst_shake_rst", shake_rst, 1);
    chk("rst_in_ready", shake_in_ready, 0);
    chk("rst_is_last", shake_is_last, 0);
    chk("rst_byte_num", shake_byte_num, 0);
    chk("rst_shake_in", shake_in, 0);
    rst = 1'b0;
    tick();

    // start coincident with reset must be dropped
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    repeat (3) tick();
    chk("start_during_rst_busy", busy, 0);
    chk("start_during_rst_rstout", shake_rst, 1);

    run(0, 1'b1, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0, 1'b0);
    run(2, 1'b0, 1'b0, 1'b0);
    run(3, 1'b0, 1'b0, 1'b0);
    run(4, 1'b0, 1'b1, 1'b0);
    run(4, 1'b0, 1'b0, 1'b1);
    run(4, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cbd_sampler_param.md
Name: cbd_sampler_param

Overview:
- Parametrised centred-binomial noise sampler for the NewHope core; generalised successor of the fixed 512-point, k=8 sampler.
- Absorbs a 32-byte seed from the byte RAM plus nonce and block index into SHAKE256, then squeezes one output block per absorb.
- Converts each block into fully reduced coefficients in [0, Q-1] and writes them to the polynomial RAM at one coefficient per clock, pipelined.
- Used for the s, e, e' noise polynomials at N=512 or N=1024.

Parameters:
- N, 1024, polynomial length; must be a multiple of CPB; N/CPB ≤ 256.
- K, 8, binomial parameter; each coefficient consumes 2K bits; K ≤ 15.
- Q, 12289, modulus.
- BLOCK_BITS, 1024, SHAKE output bits consumed per block; must be a multiple of 2K.
- COEF_W, 16, width of written coefficient.
- Derived: CPB = BLOCK_BITS/(2K); NBLK = N/CPB; AW = clog2(N).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle start pulse; ignored while busy
- nonce  in  8  nonce byte, sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last coefficient write
- byte_addr  out  3  seed RAM word address; read latency 1
- byte_do  in  32  seed RAM data
- poly_wea  out  1  poly RAM write enable
- poly_addra  out  AW  poly RAM address
- poly_dia  out  COEF_W  coefficient data
- shake_rst  out  1  SHAKE core reset
- shake_in  out  32  absorb word
- shake_in_ready  out  1  absorb word valid
- shake_is_last  out  1  final absorb word
- shake_byte_num  out  2  valid bytes in final word
- shake_out  in  [0:BLOCK_BITS-1]  squeezed block, MSB-first index
- shake_out_ready  in  1  shake_out valid

Behaviour:
- Reset values: busy=0, done=0, poly_wea=0, poly_addra=0, poly_dia=0, byte_addr=0, shake_rst=1, shake_in_ready=0, shake_is_last=0, shake_byte_num=0; FSM state=IDLE; counters=0.
- FSM: IDLE -> LOAD -> LAST -> WAIT_SHAKE -> PARSE -> (LOAD for next block | IDLE).
- IDLE:
  - shake_rst=1.
  - On start: latch nonce, set blk=0, busy=1, go to LOAD.
- LOAD:
  - shake_rst=0.
  - byte_addr steps 0..7 on consecutive cycles.
  - shake_in=byte_do with shake_in_ready=1 on the 8 cycles that follow each address.
  - Seed words are absorbed in order 0..7 with no gaps.
- LAST:
  - One cycle: shake_in={nonce, blk[7:0], 16'h0000}, shake_in_ready=1, shake_is_last=1, shake_byte_num=2.
  - Otherwise shake_in is 0 when not valid.
- WAIT_SHAKE: hold until shake_out_ready=1, then register shake_out into an internal block buffer and enter PARSE.
- PARSE pipeline, coefficient c = 0..CPB-1:
  - Stage 1: a = popcount(buf[2Kc +: K]), b = popcount(buf[2Kc+K +: K]).
  - Stage 2: r = a-b if a ≥ b, else Q+a-b. Result is always in [0, Q-1], zero-extended to COEF_W.
  - Stage 3: poly_wea=1, poly_addra=blk*CPB+c, poly_dia=r.
  - One write per cycle once the pipe is filled; latency from buffer load to first write is 3 cycles.
- Block end, after the write for c=CPB-1:
  - shake_rst=1 for exactly one cycle.
  - If blk < NBLK-1: blk+1, back to LOAD.
  - Else: done=1 for one cycle in the cycle after the final write, busy=0, go to IDLE.
- Total writes per run: exactly N, each address 0..N-1 written once.
- start while busy: ignored, no state change.
- start coincident with rst: rst wins.
- rst mid-run (any state): next cycle is IDLE with reset outputs; no further writes; in-flight pipeline contents discarded; done not asserted.
- shake_out_ready while not in WAIT_SHAKE: ignored.

Optional Feature:
- Macro: CBD_SAMPLER_BITREV_EN.
- Defined: poly_addra is the AW-bit bit-reversal of blk*CPB+c, so the output lands in NTT bit-reversed order.
- Undefined: natural order as above.
- Data values and timing are identical in both cases.

Test Plan:
- K=8, N=1024, SHAKE model returns all-zero blocks -> 1024 writes all 0, done once, 16 absorb sequences; last words {nonce, 0x00..0x0F, 0000}, shake_byte_num=2.
- Seed RAM words 0x00000000..0x00000007, nonce=0xA5 -> shake_in sequence 0..7 then 0xA5000000 for block 0, no gaps in shake_in_ready.
- Block pattern per coefficient a-bits=0xFF, b-bits=0x00 -> all coefficients 8; swapped pattern (a=0x00, b=0xFF) -> all 12281; mixed a=0x0F, b=0x01 -> 3.
- Second start pulse during block 5 -> ignored; write count still exactly 1024, single done pulse.
- rst asserted on the 20th write of block 3 -> poly_wea=0 from the next cycle, shake_rst=1, busy=0; a fresh start then completes normally.
- CBD_SAMPLER_BITREV_EN with N=1024: coefficient index 1 written to address 512, index 2 to address 256; value set matches the natural-order run.
